seg7_display_driver: RTL and testbench

- Downstream consumer of the CPU's 8-bit `display` output (low byte of the ALU result).
- Converts the byte to hex, unsigned-decimal or signed-decimal digits using a sequential double-dabble engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the CPU top level and board pins.

---
 rtl/seg7_display_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg7_display_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_driver.sv
// rtl/seg7_display_driver.sv - byte to hex/decimal digits, multiplexed onto a 4-digit 7-seg display
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   value  - byte to display
//   mode   - 00 hex, 01 unsigned decimal, 10 signed decimal, 11 blank
//   seg    - segments {g,f,e,d,c,b,a}, active-low, registered
//   an     - digit anodes, active-low, an[0] = rightmost digit, registered
//   busy   - high while a conversion is in progress
module seg7_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic [1:0] mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    // Digit codes: 0..15 are hex nibbles, then two symbols.
    localparam logic [4:0] D_MINUS = 5'd16;
    localparam logic [4:0] D_BLANK = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t      state, next_state;
    logic        start;
    logic        valid;
    logic [1:0]  snap_mode;
    logic [7:0]  snap_value;
    logic        sign;
    logic [11:0] bcd;
    logic [7:0]  mag;
    logic [2:0]  iter;
    logic [4:0]  digit     [4];
    logic [4:0]  new_digit [4];
    logic        neg_in;
    logic [7:0]  mag_in;
    logic [11:0] bcd_adj;
    logic [3:0]  hundreds, tens, ones;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]  idx;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'd0:    seg_decode = 7'h40;
            5'd1:    seg_decode = 7'h79;
            5'd2:    seg_decode = 7'h24;
            5'd3:    seg_decode = 7'h30;
            5'd4:    seg_decode = 7'h19;
            5'd5:    seg_decode = 7'h12;
            5'd6:    seg_decode = 7'h02;
            5'd7:    seg_decode = 7'h78;
            5'd8:    seg_decode = 7'h00;
            5'd9:    seg_decode = 7'h10;
            5'd10:   seg_decode = 7'h08;
            5'd11:   seg_decode = 7'h03;
            5'd12:   seg_decode = 7'h46;
            5'd13:   seg_decode = 7'h21;
            5'd14:   seg_decode = 7'h06;
            5'd15:   seg_decode = 7'h0E;
            5'd16:   seg_decode = 7'h3F;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // Signed mode converts negative bytes to their magnitude; 8'h80 yields 128.
    assign neg_in = (mode == 2'b10) && value[7];
    assign mag_in = neg_in ? (~value + 8'd1) : value;

    // Double-dabble correction applied before each shift.
    assign bcd_adj[3:0]  = (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0];
    assign bcd_adj[7:4]  = (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4];
    assign bcd_adj[11:8] = (bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8];

    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

    always_comb begin
        new_digit[0] = D_BLANK;
        new_digit[1] = D_BLANK;
        new_digit[2] = D_BLANK;
        new_digit[3] = D_BLANK;
        case (snap_mode)
            2'b00: begin
                new_digit[1] = {1'b0, snap_value[7:4]};
                new_digit[0] = {1'b0, snap_value[3:0]};
            end
            2'b01, 2'b10: begin
                new_digit[3] = (snap_mode == 2'b10 && sign) ? D_MINUS : D_BLANK;
                new_digit[2] = (hundreds == 4'd0) ? D_BLANK : {1'b0, hundreds};
                new_digit[1] = (hundreds == 4'd0 && tens == 4'd0) ? D_BLANK : {1'b0, tens};
                new_digit[0] = {1'b0, ones};
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!valid || {mode, value} != {snap_mode, snap_value}) begin
                    start      = 1'b1;
                    next_state = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (iter == 3'd7)
                    next_state = S_COMMIT;
            end
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid      <= 1'b0;
            snap_mode  <= 2'b00;
            snap_value <= 8'h00;
            sign       <= 1'b0;
            bcd        <= 12'h000;
            mag        <= 8'h00;
            iter       <= 3'd0;
            busy       <= 1'b0;
            digit[0]   <= D_BLANK;
            digit[1]   <= D_BLANK;
            digit[2]   <= D_BLANK;
            digit[3]   <= D_BLANK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_mode  <= mode;
                        snap_value <= value;
                        mag        <= mag_in;
                        sign       <= neg_in;
                        bcd        <= 12'h000;
                        iter       <= 3'd0;
                        busy       <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    iter       <= iter + 3'd1;
                end
                S_COMMIT: begin
                    digit[0] <= new_digit[0];
                    digit[1] <= new_digit[1];
                    digit[2] <= new_digit[2];
                    digit[3] <= new_digit[3];
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Scan runs freely; an and seg both register from the pre-edge index so they stay paired.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an       <= 4'b1111;
            seg      <= 7'h7F;
        end else begin
            if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_decode(digit[idx]);
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// tb/tb_seg7_display_driver.sv - self-checking bench for seg7_display_driver
module tb_seg7_display_driver;

    localparam int DIV = 4;

    // Indices 0..15 hex glyphs, 16 minus, 17 blank.
    localparam logic [6:0] SEG_TAB [18] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h3F, 7'h7F
    };

    logic       clock;
    logic       reset;
    logic [7:0] value;
    logic [1:0] mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .mode  (mode),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: glyph index for display position pos (0 = rightmost).
    function automatic int ref_code(int v, int m, int pos);
        int mg, h, t, o;
        bit neg;
        if (m == 3) return 17;
        if (m == 0) begin
            if (pos == 0) return v % 16;
            if (pos == 1) return v / 16;
            return 17;
        end
        neg = (m == 2) && (v >= 128);
        mg  = neg ? 256 - v : v;
        h   = mg / 100;
        t   = (mg / 10) % 10;
        o   = mg % 10;
        case (pos)
            3: return neg ? 16 : 17;
            2: return (h == 0) ? 17 : h;
            1: return (h == 0 && t == 0) ? 17 : t;
            default: return o;
        endcase
    endfunction

    function automatic int an_to_pos(logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int pos;
        reset = 1'b0;
        value = 8'h00;
        mode  = 2'b00;
        repeat (3) @(negedge clock);
        n_checks++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
        n_checks++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clock);
            pos     = ((k - 1) / DIV) % 4;
            exp_an  = ~(4'b0001 << pos);
            exp_seg = (k <= 10) ? 7'h7F : SEG_TAB[ref_code(0, 0, pos)];
            n_checks++;
            if (an !== exp_an) begin
                n_fail++; $display("FAIL scan_an edge %0d: got %b want %b", k, an, exp_an);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL scan_seg edge %0d: got %h want %h", k, seg, exp_seg);
            end
            n_checks++;
            if (busy !== (k <= 9)) begin
                n_fail++; $display("FAIL reset_conv_busy edge %0d: got %b want %b", k, busy, (k <= 9));
            end
        end
    endtask

    // Apply a value/mode, let the conversion finish and check a full scan of the display.
    task automatic test_value(int v, int m);
        int pos;
        logic [6:0] exp_seg;
        @(negedge clock);
        value = 8'(v);
        mode  = 2'(m);
        repeat (12) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL value_busy v=%0d m=%0d: got %b want 0", v, m, busy); end
        for (int k = 0; k < 4 * DIV; k++) begin
            @(negedge clock);
            pos = an_to_pos(an);
            n_checks++;
            if (pos < 0) begin
                n_fail++; $display("FAIL value_an v=%0d m=%0d: got %b want one digit low", v, m, an);
            end else begin
                exp_seg = SEG_TAB[ref_code(v, m, pos)];
                if (seg !== exp_seg) begin
                    n_fail++;
                    $display("FAIL value_seg v=%0d m=%0d pos=%0d: got %h want %h", v, m, pos, seg, exp_seg);
                end
            end
        end
    endtask

    task automatic test_directed();
        test_value(255, 1);
        test_value(128, 2);
        test_value(255, 2);
        test_value(7, 1);
        test_value(0, 1);
        test_value(8'hA5, 0);
        test_value(8'h3C, 3);
        test_value(127, 2);
        test_value(100, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            test_value(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    endtask

    task automatic test_back_to_back();
        int pos;
        logic [6:0] exp_seg;
        test_value(50, 1);
        @(negedge clock);
        value = 8'd10;
        mode  = 2'b01;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_capture_busy: got %b want 1", busy); end
        repeat (2) @(negedge clock);
        value = 8'd99;
        repeat (7) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_commit_busy: got %b want 0", busy); end
        for (int k = 11; k <= 20; k++) begin
            @(negedge clock);
            n_checks++;
            if (busy !== (k <= 19)) begin
                n_fail++; $display("FAIL b2b_reconv_busy edge %0d: got %b want %b", k, busy, (k <= 19));
            end
            pos = an_to_pos(an);
            exp_seg = (pos < 0) ? 7'hxx : SEG_TAB[ref_code(10, 1, pos)];
            n_checks++;
            if (pos < 0 || seg !== exp_seg) begin
                n_fail++; $display("FAIL b2b_first_seg edge %0d: got %h an %b want %h", k, seg, an, exp_seg);
            end
        end
        for (int k = 0; k < 4 * DIV; k++) begin
            @(negedge clock);
            pos = an_to_pos(an);
            exp_seg = (pos < 0) ? 7'hxx : SEG_TAB[ref_code(99, 1, pos)];
            n_checks++;
            if (pos < 0 || seg !== exp_seg) begin
                n_fail++; $display("FAIL b2b_final_seg: got %h an %b want %h", seg, an, exp_seg);
            end
        end
    endtask

    task automatic test_reset_mid_convert();
        test_value(20, 1);
        @(negedge clock);
        value = 8'd200;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL abort_seg: got %h want 7f", seg); end
        n_checks++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL abort_an: got %b want 1111", an); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(negedge clock);
        reset = 1'b1;
        test_value(200, 1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_convert();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
